// File: rtl/output_mem_drain_if.sv
// Bundle of the drain engine's control, RAM read port and host stream.
// The master side is the drain engine itself; the slave side is whatever
// surrounds it (controller, output RAM and host).

`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif

interface output_mem_drain_if #(
    parameter int DATA_W = `MEM_PORT_WIDTH,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words;

    logic              rd_mem_en;
    logic [ADDR_W-1:0] rd_mem_addr;
    logic [DATA_W-1:0] rd_mem_data;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  word_count;

    modport master (
        input  start, base_addr, num_words, rd_mem_data, out_ready,
        output rd_mem_en, rd_mem_addr, out_valid, out_data, out_last,
               busy, done, word_count
    );

    modport slave (
        output start, base_addr, num_words, rd_mem_data, out_ready,
        input  rd_mem_en, rd_mem_addr, out_valid, out_data, out_last,
               busy, done, word_count
    );
endinterface

// File: rtl/output_mem_drain.sv
// Read-side drain engine for the output RAM. Reads a contiguous run of
// words and streams them to the host through a small return FIFO. Reads
// are only issued when the FIFO is guaranteed to have room for every
// outstanding word, so host backpressure never drops or duplicates data.

`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif

module output_mem_drain #(
    parameter int DATA_W     = `MEM_PORT_WIDTH,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output_mem_drain_if.master    bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_FW + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  num_words_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  word_count_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              busy_q;
    logic              done_q;

    // data_ret marks the cycle in which rd_mem_data carries a requested word
    logic              data_ret;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] fifo_count;

    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;
    logic              credit_ok;

    // Occupancy counts FIFO words plus reads still on their way back; all
    // terms are registered so out_ready never reaches the read strobe.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(rd_en_q) + OCC_W'(data_ret);
    assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);

    assign push = data_ret;
    assign pop  = bus.out_valid & bus.out_ready;

    assign bus.out_valid   = (fifo_count != '0);
    assign bus.out_data    = bus.out_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.out_last    = bus.out_valid && (word_count_q == num_words_q - 1'b1);
    assign bus.rd_mem_en   = rd_en_q;
    assign bus.rd_mem_addr = rd_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.word_count  = word_count_q;

    // Run sequencing: accept start, issue credited reads, wait for drain, pulse done
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            num_words_q  <= '0;
            issued       <= '0;
            word_count_q <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (pop) begin
                word_count_q <= word_count_q + 1'b1;
            end
            case (state)
                IDLE: begin
                    rd_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        word_count_q <= '0;
                        num_words_q  <= bus.num_words;
                        if (bus.num_words != '0) begin
                            rd_addr_q <= bus.base_addr;
                            rd_en_q   <= 1'b1;
                            issued    <= CNT_W'(1);
                            busy_q    <= 1'b1;
                            state     <= READ;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                READ: begin
                    if (issued == num_words_q) begin
                        rd_en_q <= 1'b0;
                        state   <= FLUSH;
                    end else if (credit_ok) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + 1'b1;
                        issued    <= issued + 1'b1;
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    rd_en_q <= 1'b0;
                    if (!rd_en_q && !data_ret &&
                        ((fifo_count == '0) ||
                         (fifo_count == CNT_FW'(1) && pop))) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Return-FIFO bookkeeping; reset discards any read still in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_ret   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            data_ret <= rd_en_q;
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Return-FIFO storage, written with the word arriving from the RAM
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.rd_mem_data;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && fifo_count == CNT_FW'(FIFO_DEPTH)));

    credit_chk: assert property (@(posedge clk) disable iff (!rst)
        occupancy <= OCC_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_output_mem_drain.sv
// Bench for output_mem_drain: directed scenarios plus randomized runs,
// checked against an expected word list built from base address and length.

module tb_output_mem_drain;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic [31:0] data_key;
    int          tests_run;
    int          tests_failed;

    output_mem_drain_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    output_mem_drain #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output RAM model: word content is its address xor a per-run key
    always @(posedge clk) begin
        bus.rd_mem_data <= bus.rd_mem_en ? (bus.rd_mem_addr ^ data_key) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_en"},   bus.rd_mem_en, 0);
        checkOutput({tag, "_rd_addr"}, bus.rd_mem_addr, 0);
        checkOutput({tag, "_valid"},   bus.out_valid, 0);
        checkOutput({tag, "_data"},    bus.out_data, 0);
        checkOutput({tag, "_last"},    bus.out_last, 0);
        checkOutput({tag, "_busy"},    bus.busy, 0);
        checkOutput({tag, "_done"},    bus.done, 0);
        checkOutput({tag, "_wcount"},  bus.word_count, 0);
    endtask

    // One drain run; caller is at a negedge in an idle cycle.
    // mode 0: ready always high (exact timing checked), 1: random ready,
    // 2: ready low in cycles 4..9. inject pulses a second start mid-run.
    task automatic applyStimulus(input logic [31:0] base, input int n,
                                 input int mode, input bit inject);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        int  issued_cnt = 0;
        int  popped = 0;
        int  last_hs = -1;
        int  done_cycle = -1;
        int  budget = 30 * n + 50;
        bit  prev_stall = 0;
        bit  ready_now;
        bit  hs;

        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(base + 32'(i));
            exp_data.push_back((base + 32'(i)) ^ data_key);
        end

        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_words = CNT_W'(n);
        @(negedge clk);
        bus.start = 1'b0;

        for (int c = 1; c <= budget; c++) begin
            case (mode)
                0:       ready_now = 1'b1;
                1:       ready_now = ($urandom_range(0, 3) != 0);
                default: ready_now = !(c >= 4 && c <= 9);
            endcase
            bus.out_ready = ready_now;
            if (inject && c == 3) begin
                bus.start     = 1'b1;
                bus.base_addr = ~base;
                bus.num_words = CNT_W'(n + 5);
            end else begin
                bus.start = 1'b0;
            end

            if (prev_stall) checkOutput("hold_valid", bus.out_valid, 1);

            if (bus.rd_mem_en) begin
                if (issued_cnt < n)
                    checkOutput("rd_addr", bus.rd_mem_addr, exp_addr[issued_cnt]);
                else
                    checkOutput("read_count", issued_cnt + 1, n);
                issued_cnt++;
            end
            checkOutput("credit", (issued_cnt - popped) <= DEPTH, 1);

            if (mode == 0) begin
                checkOutput("rd_en_timing", bus.rd_mem_en, (c >= 1 && c <= n));
                checkOutput("valid_timing", bus.out_valid, (c >= 3 && c <= n + 2));
            end

            if (bus.out_valid) begin
                if (popped < n) begin
                    checkOutput("data", bus.out_data, exp_data[popped]);
                    checkOutput("last", bus.out_last, popped == n - 1);
                end else begin
                    checkOutput("extra_word", popped, n - 1);
                end
            end else begin
                checkOutput("last_idle", bus.out_last, 0);
            end

            checkOutput("done", bus.done, (last_hs >= 0 && c == last_hs + 1));
            checkOutput("busy", bus.busy, !(last_hs >= 0 && c > last_hs));
            if (bus.done) done_cycle = c;

            hs = bus.out_valid && ready_now;
            if (hs) begin
                popped++;
                if (popped == n) last_hs = c;
            end
            prev_stall = bus.out_valid && !ready_now;
            if (done_cycle > 0) break;
            @(negedge clk);
        end

        checkOutput("done_seen", done_cycle > 0, 1);
        checkOutput("word_count", bus.word_count, n);
        checkOutput("reads", issued_cnt, n);
        checkOutput("words", popped, n);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("done_pulse", bus.done, 0);
        checkOutput("wcount_hold", bus.word_count, n);
    endtask

    // Zero-length run: done in cycle 1, no reads, never busy
    task automatic applyZeroRun();
        bus.start     = 1'b1;
        bus.base_addr = 32'h55;
        bus.num_words = '0;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("zero_done", bus.done, 1);
        checkOutput("zero_busy", bus.busy, 0);
        checkOutput("zero_rd_en", bus.rd_mem_en, 0);
        checkOutput("zero_wcount", bus.word_count, 0);
        @(negedge clk);
        checkOutput("zero_done_end", bus.done, 0);
        checkOutput("zero_busy_end", bus.busy, 0);
        checkOutput("zero_rd_en_end", bus.rd_mem_en, 0);
    endtask

    // Reset pulse while two words sit in the FIFO, then a fresh 2-word run
    task automatic applyResetMidRun();
        data_key      = 32'h0000_5A5A;
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        bus.base_addr = 32'h40;
        bus.num_words = CNT_W'(8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_valid", bus.out_valid, 1);
        checkOutput("mid_busy", bus.busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkResetValues("mid_reset");
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_valid", bus.out_valid, 0);
        checkOutput("post_reset_busy", bus.busy, 0);
        applyStimulus(32'h0, 2, 0, 1'b0);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        data_key      = 32'hA5;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(32'h100, 4, 0, 1'b0);
        applyStimulus(32'h200, 10, 2, 1'b0);
        applyZeroRun();
        applyStimulus(32'h300, 6, 0, 1'b1);
        applyResetMidRun();
        data_key = 32'hA5;
        applyStimulus(32'hFFFF_FFFE, 3, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            logic [31:0] base;
            int          n;
            data_key = $urandom;
            base     = (r % 3 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            n        = $urandom_range(1, 24);
            applyStimulus(base, n, (r % 4 == 0) ? 0 : 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
